// File: rtl/sysid_checker.sv
// Reads the system ID and build timestamp words from a sysid slave and compares
// them with the expected values. A check runs on request or once after reset.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1400059473,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [7:0]  mismatch_count
);

    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CMP   = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  wait_count;
    logic        wait_last;
    logic        auto_pending;
    logic [31:0] id_capture;
    logic [31:0] ts_capture;
    logic        id_eq;
    logic        ts_eq;

    assign wait_last = (wait_count == WAIT_LAST);
    assign id_eq     = (id_capture == EXPECTED_ID);
    assign ts_eq     = (ts_capture == EXPECTED_TS);

    // Next-state logic; start only matters in IDLE, so it is ignored while busy.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start || auto_pending) next_state = RD_ID;
                else                       next_state = IDLE;
            end
            RD_ID: begin
                if (wait_last) next_state = RD_TS;
                else           next_state = RD_ID;
            end
            RD_TS: begin
                if (wait_last) next_state = CMP;
                else           next_state = RD_TS;
            end
            CMP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register, shared wait counter (cleared on every state entry) and auto-start flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_count   <= 3'd0;
            auto_pending <= AUTO_START;
        end else begin
            state        <= next_state;
            auto_pending <= 1'b0;
            if (next_state != state || state == IDLE) wait_count <= 3'd0;
            else                                      wait_count <= wait_count + 3'd1;
        end
    end

    // Raw captures; published outputs only change when the check completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_capture <= 32'd0;
            ts_capture <= 32'd0;
        end else begin
            if (state == RD_ID && wait_last) id_capture <= sysid_readdata;
            if (state == RD_TS && wait_last) ts_capture <= sysid_readdata;
        end
    end

    // Registered outputs, derived from the next state so they align with the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy           <= 1'b0;
            sysid_address  <= 1'b0;
            done           <= 1'b0;
            id_ok          <= 1'b0;
            ts_ok          <= 1'b0;
            match          <= 1'b0;
            id_value       <= 32'd0;
            ts_value       <= 32'd0;
            mismatch_count <= 8'd0;
        end else begin
            busy          <= (next_state != IDLE);
            sysid_address <= (next_state == RD_TS);
            done          <= (state == CMP);
            if (state == CMP) begin
                id_ok    <= id_eq;
                ts_ok    <= ts_eq;
                match    <= id_eq && ts_eq;
                id_value <= id_capture;
                ts_value <= ts_capture;
                if (!(id_eq && ts_eq) && mismatch_count != 8'hFF)
                    mismatch_count <= mismatch_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed self-checking bench for sysid_checker: a default instance (latency 1,
// auto-start) and a latency-3 instance, each driven by a latency-modelling slave.
module tb_sysid_checker;

    localparam logic [31:0] TS_A = 32'd1400059473;
    localparam logic [31:0] ID_B = 32'hA5A50001;
    localparam logic [31:0] TS_B = 32'h0BADF00D;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        match;
        logic [31:0] id_value;
        logic [31:0] ts_value;
        logic [7:0]  mm;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        addr_a, busy_a, done_a, id_ok_a, ts_ok_a, match_a;
    logic        addr_b, busy_b, done_b, id_ok_b, ts_ok_b, match_b;
    logic [31:0] rd_a, id_val_a, ts_val_a, rd_b, id_val_b, ts_val_b;
    logic [7:0]  mm_a, mm_b;

    logic [31:0] id_word_a = 32'd0;
    logic [31:0] ts_word_a = TS_A;
    logic [31:0] id_word_b = ID_B;
    logic [31:0] ts_word_b = TS_B;
    logic        addr_q_a = 1'b0;
    logic        addr_q_b = 1'b0;
    int          age_a = 0;
    int          age_b = 0;

    int   tests = 0;
    int   fails = 0;
    int   sel = 0;
    exp_t q[$];
    exp_t last;
    int   mm_model[2];

    logic        s_done, s_busy, s_addr, s_id_ok, s_ts_ok, s_match;
    logic [31:0] s_id, s_ts;
    logic [7:0]  s_mm;

    sysid_checker dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .sysid_address(addr_a), .sysid_readdata(rd_a),
        .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a),
        .match(match_a), .id_value(id_val_a), .ts_value(ts_val_a),
        .mismatch_count(mm_a)
    );

    sysid_checker #(
        .EXPECTED_ID(ID_B), .EXPECTED_TS(TS_B), .READ_LATENCY(3), .AUTO_START(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .sysid_address(addr_b), .sysid_readdata(rd_b),
        .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b),
        .match(match_b), .id_value(id_val_b), .ts_value(ts_val_b),
        .mismatch_count(mm_b)
    );

    always #5 clock = ~clock;

    // Slave models: data is only valid once the address has been stable for the latency.
    always @(posedge clock) begin
        if (addr_a != addr_q_a) age_a <= 1;
        else if (age_a < 15)    age_a <= age_a + 1;
        addr_q_a <= addr_a;
        if (addr_b != addr_q_b) age_b <= 1;
        else if (age_b < 15)    age_b <= age_b + 1;
        addr_q_b <= addr_b;
    end

    assign rd_a = (addr_a == addr_q_a && age_a >= 1) ? (addr_a ? ts_word_a : id_word_a) : 32'hDEADBEEF;
    assign rd_b = (addr_b == addr_q_b && age_b >= 3) ? (addr_b ? ts_word_b : id_word_b) : 32'hDEADBEEF;

    assign s_done  = (sel != 0) ? done_b   : done_a;
    assign s_busy  = (sel != 0) ? busy_b   : busy_a;
    assign s_addr  = (sel != 0) ? addr_b   : addr_a;
    assign s_id_ok = (sel != 0) ? id_ok_b  : id_ok_a;
    assign s_ts_ok = (sel != 0) ? ts_ok_b  : ts_ok_a;
    assign s_match = (sel != 0) ? match_b  : match_a;
    assign s_id    = (sel != 0) ? id_val_b : id_val_a;
    assign s_ts    = (sel != 0) ? ts_val_b : ts_val_a;
    assign s_mm    = (sel != 0) ? mm_b     : mm_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_last();
        last = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0};
    endtask

    // Scoreboard push: expected outcome computed from the slave words and parameters.
    task automatic push_exp(input logic [31:0] idw, input logic [31:0] tsw);
        exp_t        e;
        logic [31:0] eid;
        logic [31:0] ets;
        eid = (sel != 0) ? ID_B : 32'd0;
        ets = (sel != 0) ? TS_B : TS_A;
        e.id_ok    = (idw == eid);
        e.ts_ok    = (tsw == ets);
        e.match    = e.id_ok && e.ts_ok;
        e.id_value = idw;
        e.ts_value = tsw;
        if (!e.match && mm_model[sel] < 255) mm_model[sel]++;
        e.mm = 8'(mm_model[sel]);
        q.push_back(e);
    endtask

    // Waits (bounded) for done, checking latency, busy, address hold and results.
    task automatic wait_done(input bit drop_start);
        int   cyc;
        int   lat;
        int   a1;
        bit   seen;
        bit   busy_ok;
        exp_t e;
        cyc = 0; a1 = 0; seen = 1'b0; busy_ok = 1'b1;
        lat = (sel != 0) ? 3 : 1;
        while (!seen && cyc < 40) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (cyc == 1 && drop_start) begin
                if (sel != 0) start_b = 1'b0;
                else          start_a = 1'b0;
            end
            if (s_addr) a1++;
            if (cyc == 3) begin
                chk("hold_id_value", s_id, last.id_value);
                chk("hold_ts_value", s_ts, last.ts_value);
                chk("hold_match", s_match, last.match);
            end
            if (s_done)       seen = 1'b1;
            else if (!s_busy) busy_ok = 1'b0;
        end
        chk("done_seen", seen, 1);
        chk("latency", cyc, 2 * (lat + 1) + 2);
        chk("busy_during", busy_ok, 1);
        chk("busy_at_done", s_busy, 0);
        chk("addr_ts_cycles", a1, lat + 1);
        if (q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("id_ok", s_id_ok, e.id_ok);
            chk("ts_ok", s_ts_ok, e.ts_ok);
            chk("match", s_match, e.match);
            chk("id_value", s_id, e.id_value);
            chk("ts_value", s_ts, e.ts_value);
            chk("mismatch_count", s_mm, e.mm);
            last = e;
        end
    endtask

    task automatic idle_window(input int n);
        bit bad;
        bad = 1'b0;
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            if (s_done || s_busy) bad = 1'b1;
        end
        chk("idle_no_extra_check", bad, 0);
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_id_ok"}, id_ok_a, 0);
        chk({tag, "_ts_ok"}, ts_ok_a, 0);
        chk({tag, "_match"}, match_a, 0);
        chk({tag, "_id_value"}, id_val_a, 0);
        chk({tag, "_ts_value"}, ts_val_a, 0);
        chk({tag, "_mismatch_count"}, mm_a, 0);
    endtask

    initial begin
        bit bad;
        mm_model[0] = 0;
        mm_model[1] = 0;
        clear_last();
        sel = 0;
        repeat (3) @(negedge clock);
        check_zero_a("reset");

        // Auto-start after release: exactly one matching check.
        reset = 1'b0;
        push_exp(id_word_a, ts_word_a);
        wait_done(1'b0);
        idle_window(8);

        // Timestamp mismatch on a start pulse.
        ts_word_a = 32'h12345678;
        start_a = 1'b1;
        push_exp(id_word_a, ts_word_a);
        wait_done(1'b1);

        // Start held high: ignored while busy, one done per check.
        ts_word_a = TS_A;
        start_a = 1'b1;
        push_exp(id_word_a, ts_word_a);
        push_exp(id_word_a, ts_word_a);
        wait_done(1'b0);
        wait_done(1'b1);
        idle_window(6);

        // Mismatch counter saturation.
        ts_word_a = 32'd0;
        for (int i = 0; i < 300; i++) begin
            start_a = 1'b1;
            push_exp(id_word_a, ts_word_a);
            wait_done(1'b1);
        end
        chk("saturated_count", mm_a, 8'd255);

        // Reset during RD_TS aborts the check asynchronously.
        ts_word_a = 32'h00000001;
        start_a = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start_a = 1'b0;
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("pre_abort_addr", addr_a, 1);
        chk("pre_abort_busy", busy_a, 1);
        #2 reset = 1'b1;
        #1 check_zero_a("abort");
        mm_model[0] = 0;
        mm_model[1] = 0;
        q.delete();
        clear_last();
        ts_word_a = TS_A;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            if (done_a || busy_a) bad = 1'b1;
        end
        chk("abort_no_done", bad, 0);
        reset = 1'b0;
        push_exp(id_word_a, ts_word_a);
        wait_done(1'b0);
        idle_window(8);

        // Latency-3 instance without auto-start.
        chk("b_no_auto_busy", busy_b, 0);
        chk("b_no_auto_done", done_b, 0);
        sel = 1;
        clear_last();
        start_b = 1'b1;
        push_exp(id_word_b, ts_word_b);
        wait_done(1'b1);
        id_word_b = ID_B ^ 32'h80000000;
        start_b = 1'b1;
        push_exp(id_word_b, ts_word_b);
        wait_done(1'b1);
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
